// File: rtl/sha256_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sha256_stream_bridge
// Purpose  : Assembles bus words into SHA-256 message blocks, sequences the
//            core for first/chained blocks and serves the digest as bus words.
// Revision : 1.0
// ============================================================================
module sha256_stream_bridge #(
    parameter int BUS_WIDTH    = 32,
    parameter int BLOCK_WIDTH  = 512,
    parameter int DIGEST_WIDTH = 256,
    parameter int CMD_WIDTH    = 3
) (
    input  logic                                       io_mainClk,
    input  logic                                       io_systemReset,
    input  logic                                       wr_en,
    input  logic [BUS_WIDTH-1:0]                       wr_data,
    input  logic                                       cmd_valid,
    input  logic [CMD_WIDTH-1:0]                       cmd_reg,
    output logic                                       cmd_ready,
    output logic [$clog2(BLOCK_WIDTH/BUS_WIDTH):0]     word_count,
    output logic                                       core_start,
    output logic                                       core_init_message,
    output logic                                       core_init_iv,
    output logic [BLOCK_WIDTH-1:0]                     core_data_in,
    input  logic                                       core_busy,
    input  logic                                       core_data_out_valid,
    input  logic [DIGEST_WIDTH-1:0]                    core_data_out,
    input  logic                                       digest_rd_en,
    output logic [BUS_WIDTH-1:0]                       digest_rd_data,
    output logic                                       digest_valid,
    output logic                                       module_busy,
    output logic                                       err_drop
);

    localparam int c_WORDS  = BLOCK_WIDTH / BUS_WIDTH;
    localparam int c_DWORDS = DIGEST_WIDTH / BUS_WIDTH;
    localparam int c_CW     = $clog2(c_WORDS) + 1;
    localparam int c_IW     = $clog2(c_WORDS);
    localparam int c_PW     = $clog2(c_DWORDS);

    localparam logic [c_CW-1:0] c_FULL     = c_CW'(c_WORDS);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(c_DWORDS - 1);

    localparam logic [CMD_WIDTH-1:0] c_CMD_FIRST = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] c_CMD_NEXT  = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] c_CMD_CLEAR = CMD_WIDTH'(3);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_START = 2'd2;
    localparam logic [1:0] c_WAIT  = 2'd3;

    logic [1:0]                          r_state;
    logic [1:0]                          w_state_next;
    logic [0:c_WORDS-1][BUS_WIDTH-1:0]   r_block;
    logic [0:c_DWORDS-1][BUS_WIDTH-1:0]  r_digest;
    logic [c_CW-1:0]                     r_word_count;
    logic [c_PW-1:0]                     r_rd_ptr;
    logic                                r_digest_valid;
    logic                                r_err_drop;
    logic                                r_mode_first;

    logic              w_in_idle;
    logic              w_cmd_ready;
    logic              w_hash_cmd;
    logic              w_hash_go;
    logic              w_clear_cmd;
    logic              w_clear_go;
    logic              w_wr_ok;
    logic              w_drop;
    logic              w_capture;
    logic [c_IW-1:0]   w_wr_idx;

    assign w_in_idle   = (r_state == c_IDLE);
    assign w_cmd_ready = w_in_idle && (r_word_count == c_FULL);
    assign w_hash_cmd  = cmd_valid && ((cmd_reg == c_CMD_FIRST) || (cmd_reg == c_CMD_NEXT));
    assign w_hash_go   = w_hash_cmd && w_cmd_ready;
    assign w_clear_cmd = cmd_valid && (cmd_reg == c_CMD_CLEAR);
    assign w_clear_go  = w_clear_cmd && w_in_idle;
    // A write landing with CLEAR goes into the freshly emptied buffer.
    assign w_wr_ok     = wr_en && w_in_idle && (w_clear_go || (r_word_count < c_FULL));
    assign w_wr_idx    = w_clear_go ? '0 : r_word_count[c_IW-1:0];
    assign w_drop      = (wr_en && !w_wr_ok) || (w_hash_cmd && !w_cmd_ready)
                       || (w_clear_cmd && !w_in_idle);
    assign w_capture   = (r_state == c_WAIT) && core_data_out_valid;

    // State register
    always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_hash_go) w_state_next = c_LOAD;
            c_LOAD:  w_state_next = c_START;
            c_START: w_state_next = c_WAIT;
            c_WAIT:  if (core_data_out_valid) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        core_init_message = 1'b0;
        core_init_iv      = 1'b0;
        core_start        = 1'b0;
        case (r_state)
            c_LOAD: begin
                core_init_message = 1'b1;
                core_init_iv      = r_mode_first;
            end
            c_START: core_start = 1'b1;
            default: ;
        endcase
        cmd_ready   = w_cmd_ready;
        module_busy = !w_in_idle || core_busy;
    end

    always_ff @(posedge io_mainClk or posedge io_systemReset) begin
        if (io_systemReset) begin
            r_block        <= '0;
            r_digest       <= '0;
            r_word_count   <= '0;
            r_rd_ptr       <= '0;
            r_digest_valid <= 1'b0;
            r_err_drop     <= 1'b0;
            r_mode_first   <= 1'b0;
        end else begin
            if (w_clear_go) r_block <= '0;
            if (w_wr_ok)    r_block[w_wr_idx] <= wr_data;

            if (w_capture)       r_word_count <= '0;
            else if (w_clear_go) r_word_count <= w_wr_ok ? c_ONE : '0;
            else if (w_wr_ok)    r_word_count <= r_word_count + 1'b1;

            if (w_hash_go) r_mode_first <= (cmd_reg == c_CMD_FIRST);

            if (w_capture) r_digest <= core_data_out;

            if (w_capture)                             r_digest_valid <= 1'b1;
            else if ((r_state == c_LOAD) || w_clear_go) r_digest_valid <= 1'b0;

            if (w_capture)         r_rd_ptr <= '0;
            else if (digest_rd_en) r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

            r_err_drop <= (r_err_drop && !w_clear_go) || w_drop;
        end
    end

    assign word_count     = r_word_count;
    assign core_data_in   = r_block;
    assign digest_rd_data = r_digest[r_rd_ptr];
    assign digest_valid   = r_digest_valid;
    assign err_drop       = r_err_drop;

endmodule
`default_nettype wire

// File: doc/sha256_stream_bridge.md
Name: sha256_stream_bridge

Overview:
- Parametrised successor to the single-shot SHA-256 bridge; sits between the CPU register bus and the `sha256` core.
- Assembles 512-bit message blocks from narrow bus-word writes.
- Sequences the core's init_iv/init_message/start pins for first and chained blocks, and captures the 256-bit digest on data_out_valid.
- Serves the digest back as bus words through a wrapping read pointer.

Parameters:
- BUS_WIDTH, 32, bus word width; must divide BLOCK_WIDTH and DIGEST_WIDTH.
- BLOCK_WIDTH, 512, message block width fed to core data_in.
- DIGEST_WIDTH, 256, core data_out width.
- CMD_WIDTH, 3, command field width.

Ports:
- io_mainClk  in  1  single clock.
- io_systemReset  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write one message word this cycle.
- wr_data  in  BUS_WIDTH  message word.
- cmd_valid  in  1  command strobe.
- cmd_reg  in  CMD_WIDTH  command: 000 NOP, 001 HASH_FIRST, 010 HASH_NEXT, 011 CLEAR; others ignored.
- cmd_ready  out  1  high in IDLE with buffer full.
- word_count  out  $clog2(BLOCK_WIDTH/BUS_WIDTH)+1  words currently buffered.
- core_start  out  1  one-cycle start pulse to core.
- core_init_message  out  1  one-cycle data_in load pulse.
- core_init_iv  out  1  one-cycle IV reload pulse.
- core_data_in  out  BLOCK_WIDTH  assembled block.
- core_busy  in  1  core busy.
- core_data_out_valid  in  1  core digest valid.
- core_data_out  in  DIGEST_WIDTH  core digest.
- digest_rd_en  in  1  advance digest read pointer.
- digest_rd_data  out  BUS_WIDTH  current digest word.
- digest_valid  out  1  digest captured and not stale.
- module_busy  out  1  FSM not in IDLE, or core_busy.
- err_drop  out  1  sticky: a write or command was dropped.

Behaviour:
- Reset: every output, buffer, digest register, word_count and read pointer go to 0; FSM goes to IDLE. Reset mid-hash abandons the hash without waiting for the core.
- Word buffer, WORDS = BLOCK_WIDTH/BUS_WIDTH:
  - First written word lands at core_data_in[BLOCK_WIDTH-1 -: BUS_WIDTH]; later words go to successively lower slices.
  - word_count increments on each accepted write.
  - Writes are accepted only in IDLE with word_count < WORDS. Any other write is dropped and sets err_drop; buffer is unchanged.
- FSM states: IDLE, LOAD, START, WAIT.
  - IDLE → LOAD on cmd_valid with HASH_FIRST or HASH_NEXT while cmd_ready. The mode bit is latched.
  - LOAD, 1 cycle: core_init_message=1. core_init_iv=1 only for HASH_FIRST. digest_valid cleared.
  - START, 1 cycle: core_start=1.
  - WAIT: hold until core_data_out_valid=1. In that cycle capture core_data_out, set digest_valid=1, reset read pointer to 0, clear word_count to 0, go to IDLE.
- Minimum latency from command to digest_valid: 3 cycles plus core latency.
- Command handling:
  - A hash command while !cmd_ready is ignored and sets err_drop.
  - CLEAR is accepted in IDLE only. It zeroes the buffer, word_count, digest_valid and err_drop.
  - CLEAR outside IDLE is ignored and sets err_drop.
  - NOP and undefined codes: no effect.
  - A cmd_valid and a wr_en in the same cycle: the command is evaluated against the pre-write word_count; the write is then processed per the buffer rules.
- core_data_in is driven from the buffer continuously. The buffer is not modified between LOAD and WAIT exit.
- Digest read, DWORDS = DIGEST_WIDTH/BUS_WIDTH:
  - digest_rd_data = digest word at the pointer; word 0 = MSB slice.
  - digest_rd_en increments the pointer, wrapping DWORDS-1 → 0.
  - Reads are allowed in any state; data is stale while digest_valid=0.
- core_data_out_valid outside WAIT is ignored.
- module_busy = (state != IDLE) | core_busy.

Test Plan:
- Reset, write 16 words 0x61626380, 0x00000000 ×14, 0x00000018 (padded "abc"), then HASH_FIRST. Required: cmd_ready=1 before the command; LOAD asserts init_iv+init_message, then one start pulse; digest_valid rises. Eight rd_en reads give BA7816BF … F20015AD; the ninth read returns BA7816BF (wrap).
- Two-block 56-char NIST message: HASH_FIRST on block 1, then HASH_NEXT on block 2. Required: init_iv=0 in the second LOAD; final digest 248D6A61 … 19DB06C1.
- 17th write with a full buffer. Required: err_drop=1, word_count stays 16, block unchanged. Then CLEAR → word_count=0, err_drop=0.
- HASH_FIRST with 5 words buffered, and a write during WAIT. Required: command ignored / write dropped; err_drop=1; no core_start pulse.
- Assert io_systemReset during WAIT, asynchronously between clock edges. Required: all outputs 0 immediately. A later core_data_out_valid pulse leaves digest_valid=0.
- Same-cycle HASH_FIRST with the 16th wr_en. Required: command ignored (pre-write count 15), err_drop=1, word_count=16 afterwards.
